// File: rtl/output_drain_if.sv
// Output stream bundle of the accumulator drain engine.
// Carries one signed word per valid/ready handshake plus an end-of-run flag.
interface output_drain_if #(
  parameter int W = 16
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;
  logic         last;

  modport master (
    output data,
    output valid,
    output last,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    input  last,
    output ready
  );
endinterface

// File: rtl/output_drain.sv
// Port-B read-out engine for the output accumulation BRAM.
// Streams a wrapped address range out, optionally zeroing and ReLU-clamping.
module output_drain #(
  parameter int I_WIDTH         = 8,
  parameter int F_WIDTH         = 8,
  parameter int BRAM_ADDR_WIDTH = 11,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         start_i,
  input  logic [BRAM_ADDR_WIDTH-1:0]   base_addr_i,
  input  logic [BRAM_ADDR_WIDTH:0]     length_i,
  input  logic                         clear_en_i,
  input  logic                         relu_en_i,
  output logic [BRAM_ADDR_WIDTH-1:0]   bram_addr_o,
  output logic                         bram_wr_en_o,
  input  logic [I_WIDTH+F_WIDTH-1:0]   bram_data_i,
  output_drain_if.master               m,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int DW = I_WIDTH + F_WIDTH;
  localparam int AW = BRAM_ADDR_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [AW:0]   MAX_LEN  = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   LEFT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [AW-1:0]     r_addr;
  logic [AW:0]       r_left;
  logic              r_clear;
  logic              r_relu;
  logic              r_infl;
  logic              r_infl_last;

  logic [DW:0]       r_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic [AW:0]       w_len;
  logic              w_credit;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_valid;
  logic [DW-1:0]     w_push_data;
  logic [DW:0]       w_head;

  assign w_len = (length_i > MAX_LEN) ? MAX_LEN : length_i;

  // Words sitting in the FIFO plus the read on the BRAM port must leave room
  assign w_credit = (r_count + {{(CW-1){1'b0}}, r_infl}) < CNT_MAX;
  assign w_issue  = (r_state == S_ISSUE) && w_credit;

  assign w_push  = r_infl;
  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid && m.ready;
  assign w_head  = r_mem[r_rd_ptr];

  assign w_push_data = (r_relu && bram_data_i[DW-1]) ? '0 : bram_data_i;

  assign bram_addr_o  = r_addr;
  assign bram_wr_en_o = w_issue && r_clear;

  assign m.valid = w_valid;
  assign m.data  = w_valid ? w_head[DW-1:0] : '0;
  assign m.last  = w_valid && w_head[DW];

  assign busy_o = (r_state == S_ISSUE) || (r_state == S_FLUSH);
  assign done_o = (r_state == S_DONE);

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state: done follows the cycle that pops the final word
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) w_next = (w_len == '0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        if (w_issue && r_left == LEFT_ONE) w_next = S_FLUSH;
      end
      S_FLUSH: begin
        if (!r_infl &&
            (r_count == '0 || (r_count == CNT_ONE && w_pop)))
          w_next = S_DONE;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Run parameters, address walk and the one-deep read-in-flight pipe
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_addr      <= '0;
      r_left      <= '0;
      r_clear     <= 1'b0;
      r_relu      <= 1'b0;
      r_infl      <= 1'b0;
      r_infl_last <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start_i) begin
        r_addr  <= base_addr_i;
        r_left  <= w_len;
        r_clear <= clear_en_i;
        r_relu  <= relu_en_i;
      end else if (w_issue) begin
        r_addr <= r_addr + 1'b1;
        r_left <= r_left - 1'b1;
      end
      r_infl      <= w_issue;
      r_infl_last <= w_issue && (r_left == LEFT_ONE);
    end
  end

  // Skid FIFO storage; contents are don't-care while the count is zero
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_infl_last, w_push_data};
  end

  // Skid FIFO pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_output_drain.sv
// Bench for output_drain: BRAM model, scoreboard queue and stream monitor.
// Cycle n below is the interval that starts at rising edge n.
module tb_output_drain;

  localparam int IW  = 8;
  localparam int FW  = 8;
  localparam int AW  = 11;
  localparam int DEP = 4;
  localparam int DW  = IW + FW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW:0]   len = '0;
  logic          clr = 1'b0;
  logic          relu = 1'b0;
  logic          rdy = 1'b1;
  logic [AW-1:0] baddr;
  logic          bwe;
  logic [DW-1:0] bdata;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  output_drain_if #(.W(DW)) mif ();
  assign mif.ready = rdy;

  output_drain #(
    .I_WIDTH(IW),
    .F_WIDTH(FW),
    .BRAM_ADDR_WIDTH(AW),
    .FIFO_DEPTH(DEP)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .start_i(start),
    .base_addr_i(base),
    .length_i(len),
    .clear_en_i(clr),
    .relu_en_i(relu),
    .bram_addr_o(baddr),
    .bram_wr_en_o(bwe),
    .bram_data_i(bdata),
    .m(mif),
    .busy_o(busy),
    .done_o(done)
  );

  // Read-first BRAM port B with zero write data, plus a preload port
  logic [DW-1:0] mem [2**AW];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_a = '0;
  logic [DW-1:0] pl_d = '0;

  always @(posedge clk) begin
    bdata <= mem[baddr];
    if (bwe)        mem[baddr] <= '0;
    else if (pl_en) mem[pl_a]  <= pl_d;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard and monitor
  logic [DW:0]   sbq [$];
  logic [AW-1:0] addrq [$];
  int            rcv = 0;
  int            issued = 0;
  int            max_out = 0;
  int            out_base = 0;
  int            last_hs = -1;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_d = '0;
  logic          prev_l = 1'b0;
  logic [DW:0]   expw;

  always @(negedge clk) begin
    if (bwe) begin
      issued++;
      addrq.push_back(baddr);
      if (issued - rcv - out_base > max_out)
        max_out = issued - rcv - out_base;
    end
    if (prev_stall && rst_n) begin
      check("stall_valid", 32'(mif.valid), 32'd1);
      check("stall_data", 32'(mif.data), 32'(prev_d));
      check("stall_last", 32'(mif.last), 32'(prev_l));
    end
    if (mif.valid && mif.ready) begin
      if (sbq.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL unexpected_word: got %0h expected none", mif.data);
      end else begin
        expw = sbq.pop_front();
        check("out_data", 32'(mif.data), 32'(expw[DW-1:0]));
        check("out_last", 32'(mif.last), 32'(expw[DW]));
      end
      rcv++;
      if (mif.last) last_hs = cyc;
    end
    prev_stall = mif.valid && !mif.ready;
    prev_d     = mif.data;
    prev_l     = mif.last;
  end

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    pl_en = 1'b1;
    pl_a  = a;
    pl_d  = d;
    @(posedge clk);
    #1;
    pl_en = 1'b0;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] l,
                          input logic c, input logic r, output int t0);
    @(posedge clk);
    #1;
    base  = b;
    len   = l;
    clr   = c;
    relu  = r;
    start = 1'b1;
    @(posedge clk);
    #1;
    t0    = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (done) begin
        dc = cyc;
        break;
      end
    end
    check("done_seen", 32'(dc >= 0), 32'd1);
  endtask

  task automatic expect_word(input logic [DW-1:0] d, input logic l);
    sbq.push_back({l, d});
  endtask

  logic [DW-1:0] v5  [5]  = '{16'h0001, 16'hFFFE, 16'h0003, 16'hFFFC, 16'h0005};
  logic [DW-1:0] r5  [5]  = '{16'h0001, 16'h0000, 16'h0003, 16'h0000, 16'h0005};
  logic [DW-1:0] v8  [8]  = '{16'h0010, 16'hFF00, 16'h7FFF, 16'h8000,
                              16'h0001, 16'hFFFF, 16'h1234, 16'hC000};
  logic [AW-1:0] wa  [4]  = '{11'd2046, 11'd2047, 11'd0, 11'd1};
  logic [DW-1:0] wd  [4]  = '{16'h0111, 16'h0222, 16'h0333, 16'h0444};
  logic [31:0]   pat      = 32'hFFFF_500D;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int dc;
    int i0;
    int r0;
    int a0;
    int nd;
    int nv;

    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", 32'(baddr), 32'd0);
    check("rst_wen", 32'(bwe), 32'd0);
    check("rst_valid", 32'(mif.valid), 32'd0);
    check("rst_last", 32'(mif.last), 32'd0);
    check("rst_data", 32'(mif.data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    // Plain run
    for (int i = 0; i < 5; i++) preload(AW'(10 + i), v5[i]);
    for (int i = 0; i < 5; i++) expect_word(v5[i], i == 4);
    do_start(11'd10, 12'd5, 1'b0, 1'b0, t0);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_addr", 32'(baddr), 32'd10);
    @(posedge clk);
    #1;
    check("t1_valid_early", 32'(mif.valid), 32'd0);
    @(posedge clk);
    #1;
    check("t1_valid_lat", 32'(mif.valid), 32'd1);
    wait_done(dc);
    check("t1_done_after_last", 32'(dc), 32'(last_hs + 1));
    check("t1_done_at", 32'(dc), 32'(t0 + 7));
    check("t1_sb_empty", 32'(sbq.size()), 32'd0);
    for (int i = 0; i < 5; i++)
      check("t1_bram_kept", 32'(mem[10 + i]), 32'(v5[i]));

    // ReLU plus clear
    i0 = issued;
    for (int i = 0; i < 5; i++) expect_word(r5[i], i == 4);
    do_start(11'd10, 12'd5, 1'b1, 1'b1, t0);
    wait_done(dc);
    check("t2_done_after_last", 32'(dc), 32'(last_hs + 1));
    check("t2_wen_cycles", 32'(issued - i0), 32'd5);
    check("t2_sb_empty", 32'(sbq.size()), 32'd0);
    for (int i = 0; i < 5; i++)
      check("t2_bram_zero", 32'(mem[10 + i]), 32'd0);

    // Address wrap
    for (int i = 0; i < 4; i++) preload(wa[i], wd[i]);
    for (int i = 0; i < 4; i++) expect_word(wd[i], i == 3);
    a0 = addrq.size();
    do_start(11'd2046, 12'd4, 1'b1, 1'b0, t0);
    wait_done(dc);
    check("t3_addr_count", 32'(addrq.size() - a0), 32'd4);
    for (int i = 0; i < 4; i++)
      check("t3_addr_seq", 32'(addrq[a0 + i]), 32'(wa[i]));
    check("t3_sb_empty", 32'(sbq.size()), 32'd0);

    // Backpressure with a long stall and an ignored start
    for (int i = 0; i < 8; i++) preload(AW'(100 + i), v8[i]);
    for (int i = 0; i < 8; i++) expect_word(v8[i], i == 7);
    i0 = issued;
    out_base = issued - rcv;
    max_out = 0;
    do_start(11'd100, 12'd8, 1'b1, 1'b0, t0);
    fork
      begin
        for (int i = 0; i < 32; i++) begin
          rdy = pat[i];
          if (i == 6) begin
            base  = 11'd500;
            len   = 12'd3;
            start = 1'b1;
          end else begin
            start = 1'b0;
          end
          @(posedge clk);
          #1;
        end
        start = 1'b0;
        rdy   = 1'b1;
      end
      begin
        wait_done(dc);
      end
    join
    check("t4_sb_empty", 32'(sbq.size()), 32'd0);
    check("t4_issued", 32'(issued - i0), 32'd8);
    check("t4_outstanding", 32'(max_out <= DEP), 32'd1);
    nd = 0;
    nv = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) nd++;
      if (mif.valid) nv++;
    end
    check("t4_no_extra_done", 32'(nd), 32'd0);
    check("t4_no_extra_valid", 32'(nv), 32'd0);

    // Zero length
    i0 = issued;
    r0 = rcv;
    do_start(11'd700, 12'd0, 1'b1, 1'b0, t0);
    check("t5_done", 32'(done), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("t5_no_wen", 32'(issued - i0), 32'd0);
    check("t5_no_valid", 32'(rcv - r0), 32'd0);

    // Reset in the middle of a clearing run
    for (int i = 0; i < 6; i++) preload(AW'(200 + i), DW'(16'h0A00 + i));
    for (int i = 0; i < 6; i++) expect_word(DW'(16'h0A00 + i), i == 5);
    r0 = rcv;
    do_start(11'd200, 12'd6, 1'b1, 1'b0, t0);
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #2;
      if (mif.valid && rcv - r0 == 2) break;
    end
    check("t6_third_up", 32'(rcv - r0), 32'd2);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("t6_addr", 32'(baddr), 32'd0);
    check("t6_wen", 32'(bwe), 32'd0);
    check("t6_valid", 32'(mif.valid), 32'd0);
    check("t6_last", 32'(mif.last), 32'd0);
    check("t6_data", 32'(mif.data), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    sbq.delete();
    rst_n = 1'b1;
    i0 = issued;
    repeat (5) @(posedge clk);
    #1;
    check("t6_no_wen_after", 32'(issued - i0), 32'd0);
    check("t6_first_cleared", 32'(mem[200]), 32'd0);
    check("t6_tail_kept", 32'(mem[205]), 32'h0A05);

    // Fresh run after reset
    preload(11'd300, 16'h0055);
    preload(11'd301, 16'hFF80);
    expect_word(16'h0055, 1'b0);
    expect_word(16'h0000, 1'b1);
    do_start(11'd300, 12'd2, 1'b0, 1'b1, t0);
    wait_done(dc);
    check("t7_done_after_last", 32'(dc), 32'(last_hs + 1));
    check("t7_sb_empty", 32'(sbq.size()), 32'd0);
    check("t7_bram_kept", 32'(mem[301]), 32'hFF80);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
